// File: rtl/ysyx_23060072_ifu_ctrl.sv
// ysyx_23060072_ifu_ctrl: single-entry fetch stage with IF/ID register, redirect, fetch-fault halt and fetch counter
module ysyx_23060072_ifu_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter logic [31:0] ROM_BASE  = 32'h8000_0000,
  parameter int unsigned ROM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] instr_addr_o,
  input  logic [31:0] inst_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        if_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_exc_o,
  output logic [31:0] fetch_cnt_o
);
  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HALT = 1'b1;
  localparam logic [31:0] NOP = 32'h0000_0013;
  // one extra bit so a ROM ending at 2^32 does not wrap the limit
  localparam logic [32:0] ROM_END = {1'b0, ROM_BASE} + 33'(ROM_WORDS) * 33'd4;
  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] inst_q, inst_d;
  logic        exc_q, exc_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic        fault, load, consume;
  assign instr_addr_o = pc_q;
  assign if_valid_o   = valid_q;
  assign if_pc_o      = if_pc_q;
  assign if_inst_o    = inst_q;
  assign if_exc_o     = exc_q;
  assign fetch_cnt_o  = fetch_cnt_q;
  assign fault   = (pc_q[1:0] != 2'b00) || (pc_q < ROM_BASE) || ({1'b0, pc_q} >= ROM_END);
  assign load    = (!valid_q || id_ready_i) && !redirect_i;
  assign consume = valid_q && id_ready_i;
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    valid_d     = valid_q;
    if_pc_d     = if_pc_q;
    inst_d      = inst_q;
    exc_d       = exc_q;
    fetch_cnt_d = fetch_cnt_q + {31'b0, consume && !exc_q && !redirect_i};
    if (redirect_i) begin
      pc_d    = redirect_pc_i;
      valid_d = 1'b0;
      exc_d   = 1'b0;
      state_d = RUN;
    end else if (state_q == RUN && load) begin
      valid_d = 1'b1;
      if_pc_d = pc_q;
      inst_d  = fault ? NOP : inst_rdata_i;
      exc_d   = fault;
      pc_d    = fault ? pc_q : pc_q + 32'd4;
      state_d = fault ? HALT : RUN;
    end else if (consume) begin
      // only reachable in HALT: drain the faulting entry without refilling
      valid_d = 1'b0;
      exc_d   = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      valid_q     <= 1'b0;
      if_pc_q     <= 32'h0;
      inst_q      <= 32'h0;
      exc_q       <= 1'b0;
      fetch_cnt_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
      if_pc_q     <= if_pc_d;
      inst_q      <= inst_d;
      exc_q       <= exc_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end
endmodule

// File: tb/tb_ysyx_23060072_ifu_ctrl.sv
// tb_ysyx_23060072_ifu_ctrl: directed checks of streaming, stall, redirect, faults, reset and counter wrap
module tb_ysyx_23060072_ifu_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr_addr_o;
  logic [31:0] inst_rdata_i;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        if_valid_o;
  logic        id_ready_i = 1'b0;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_exc_o;
  logic [31:0] fetch_cnt_o;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  // ROM word i holds 0xC0DE_0000 | i
  assign inst_rdata_i = 32'hC0DE_0000 | ((instr_addr_o - 32'h8000_0000) >> 2);
  ysyx_23060072_ifu_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr_addr_o(instr_addr_o), .inst_rdata_i(inst_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .if_valid_o(if_valid_o),
    .id_ready_i(id_ready_i), .if_pc_o(if_pc_o), .if_inst_o(if_inst_o), .if_exc_o(if_exc_o),
    .fetch_cnt_o(fetch_cnt_o)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic entry(input string tag, input logic v, input logic [31:0] pc,
                       input logic [31:0] inst, input logic e, input logic [31:0] cnt);
    chk({tag, "_valid"}, {31'b0, if_valid_o}, {31'b0, v});
    chk({tag, "_pc"}, if_pc_o, pc);
    chk({tag, "_inst"}, if_inst_o, inst);
    chk({tag, "_exc"}, {31'b0, if_exc_o}, {31'b0, e});
    chk({tag, "_cnt"}, fetch_cnt_o, cnt);
  endtask
  initial begin
    redirect_i = 1'b1;
    redirect_pc_i = 32'h8000_0200;
    id_ready_i = 1'b1;
    step();
    entry("reset", 1'b0, 32'h0, 32'h0, 1'b0, 32'd0);
    chk("reset_addr", instr_addr_o, 32'h8000_0000);
    redirect_i = 1'b0;
    rst_n = 1'b1;
    step();
    entry("s0", 1'b1, 32'h8000_0000, 32'hC0DE_0000, 1'b0, 32'd0);
    step();
    entry("s1", 1'b1, 32'h8000_0004, 32'hC0DE_0001, 1'b0, 32'd1);
    step();
    entry("s2", 1'b1, 32'h8000_0008, 32'hC0DE_0002, 1'b0, 32'd2);
    step();
    entry("s3", 1'b1, 32'h8000_000C, 32'hC0DE_0003, 1'b0, 32'd3);
    step();
    chk("s_cnt4", fetch_cnt_o, 32'd4);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();
    entry("st0", 1'b1, 32'h8000_0004, 32'hC0DE_0001, 1'b0, 32'd1);
    id_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      entry("stall", 1'b1, 32'h8000_0004, 32'hC0DE_0001, 1'b0, 32'd1);
      chk("stall_addr", instr_addr_o, 32'h8000_0008);
    end
    id_ready_i = 1'b1;
    step();
    entry("st_resume", 1'b1, 32'h8000_0008, 32'hC0DE_0002, 1'b0, 32'd2);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h8000_0100;
    id_ready_i = 1'b0;
    step();
    chk("rd_bubble", {31'b0, if_valid_o}, 32'd0);
    chk("rd_addr", instr_addr_o, 32'h8000_0100);
    chk("rd_cnt", fetch_cnt_o, 32'd2);
    redirect_i = 1'b0;
    step();
    entry("rd_tgt", 1'b1, 32'h8000_0100, 32'hC0DE_0040, 1'b0, 32'd2);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h8000_0102;
    id_ready_i = 1'b1;
    step();
    chk("f1_bubble", {31'b0, if_valid_o}, 32'd0);
    redirect_i = 1'b0;
    id_ready_i = 1'b0;
    step();
    entry("f1", 1'b1, 32'h8000_0102, 32'h0000_0013, 1'b1, 32'd2);
    step();
    entry("f1_hold", 1'b1, 32'h8000_0102, 32'h0000_0013, 1'b1, 32'd2);
    id_ready_i = 1'b1;
    step();
    chk("f1_drain_v", {31'b0, if_valid_o}, 32'd0);
    chk("f1_drain_e", {31'b0, if_exc_o}, 32'd0);
    chk("f1_drain_cnt", fetch_cnt_o, 32'd2);
    step();
    chk("f1_halt_v", {31'b0, if_valid_o}, 32'd0);
    chk("f1_halt_addr", instr_addr_o, 32'h8000_0102);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h8000_0400;
    step();
    redirect_i = 1'b0;
    id_ready_i = 1'b0;
    step();
    entry("f2", 1'b1, 32'h8000_0400, 32'h0000_0013, 1'b1, 32'd2);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h8000_0000;
    step();
    redirect_i = 1'b0;
    step();
    entry("f_resume", 1'b1, 32'h8000_0000, 32'hC0DE_0000, 1'b0, 32'd2);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h7FFF_FFFC;
    step();
    redirect_i = 1'b0;
    step();
    entry("f3", 1'b1, 32'h7FFF_FFFC, 32'h0000_0013, 1'b1, 32'd2);
    rst_n = 1'b0;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h8000_0100;
    step();
    entry("mid_rst", 1'b0, 32'h0, 32'h0, 1'b0, 32'd0);
    chk("mid_rst_addr", instr_addr_o, 32'h8000_0000);
    rst_n = 1'b1;
    redirect_i = 1'b0;
    id_ready_i = 1'b1;
    step();
    entry("mid_resume", 1'b1, 32'h8000_0000, 32'hC0DE_0000, 1'b0, 32'd0);
    force dut.fetch_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_cnt_q;
    step();
    entry("wrap", 1'b1, 32'h8000_0004, 32'hC0DE_0001, 1'b0, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ysyx_23060072_ifu_ctrl.md
YSYX_23060072_IFU_CTRL -- requirements
Module: ysyx_23060072_ifu_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, 32'h8000_0000, first fetch address after reset.
REQ-002 SHALL have parameter ROM_BASE, 32'h8000_0000, byte address of instruction ROM word 0.
REQ-003 SHALL have parameter ROM_WORDS, 256, ROM depth in 32-bit words.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port instr_addr_o  output  32  fetch byte address to the ROM.
REQ-007 SHALL have port inst_rdata_i  input  32  ROM read data, combinational from instr_addr_o, same cycle.
REQ-008 SHALL have port redirect_i  input  1  branch/jump/trap redirect from EX.
REQ-009 SHALL have port redirect_pc_i  input  32  redirect target.
REQ-010 SHALL have port if_valid_o  output  1  IF/ID register holds an instruction.
REQ-011 SHALL have port id_ready_i  input  1  ID accepts the IF/ID entry this cycle.
REQ-012 SHALL have port if_pc_o  output  32  PC of the IF/ID entry.
REQ-013 SHALL have port if_inst_o  output  32  instruction of the IF/ID entry.
REQ-014 SHALL have port if_exc_o  output  1  IF/ID entry is a fetch fault.
REQ-015 SHALL have port fetch_cnt_o  output  32  count of retired-to-ID non-fault fetches.

Function
REQ-016 SHALL hold fetch PC register pc_q; instr_addr_o = pc_q combinationally.
REQ-017 SHALL define fault = pc_q[1:0] != 0, or pc_q < ROM_BASE, or pc_q >= ROM_BASE + 4*ROM_WORDS (32-bit compare, no wrap).
REQ-018 SHALL implement two states: RUN, HALT.
REQ-019 SHALL define load = (!if_valid_o || id_ready_i) && !redirect_i.
REQ-020 SHALL, in RUN on load with no fault: if_valid_o<=1, if_pc_o<=pc_q, if_inst_o<=inst_rdata_i, if_exc_o<=0, pc_q<=pc_q+4 (mod 2^32).
REQ-021 SHALL, in RUN on load with fault: if_valid_o<=1, if_pc_o<=pc_q, if_inst_o<=32'h0000_0013, if_exc_o<=1, pc_q unchanged, next state HALT.
REQ-022 SHALL, with if_valid_o=1 and id_ready_i=0 and no redirect, hold if_valid_o/pc/inst/exc and pc_q stable (no fetch loss, no duplication).
REQ-023 SHALL, in HALT, perform no loads; on id_ready_i with if_valid_o=1, clear if_valid_o and if_exc_o; stay HALT until redirect_i.
REQ-024 SHALL give redirect_i top priority in any state: pc_q<=redirect_pc_i, if_valid_o<=0, if_exc_o<=0, next state RUN, regardless of id_ready_i.
REQ-025 SHALL present the redirect target on if_valid_o two cycles after the redirect cycle (one bubble cycle).
REQ-026 SHALL increment fetch_cnt_o by 1 when if_valid_o && id_ready_i && !if_exc_o && !redirect_i; wraps 32'hFFFF_FFFF -> 0.
REQ-027 SHALL not fault-check redirect_pc_i at redirect time; a faulty target faults on its fetch cycle per REQ-021.
REQ-028 SHALL sustain one instruction per cycle when id_ready_i stays high and no fault/redirect.

Reset
REQ-029 SHALL, on any rising edge with rst_n=0, set pc_q=RESET_PC, state=RUN, if_valid_o=0, if_pc_o=0, if_inst_o=0, if_exc_o=0, fetch_cnt_o=0, overriding redirect and handshake.
REQ-030 SHALL treat reset asserted mid-stall or in HALT identically to REQ-029; first valid entry appears one cycle after rst_n rises, with if_pc_o=RESET_PC.

Verification
REQ-031 SHALL verify streaming: reset, id_ready_i=1, ROM words 0..3 = A,B,C,D -> if_pc_o 0x80000000,04,08,0C on consecutive cycles with A..D; fetch_cnt_o=4 after 4 accepts.
REQ-032 SHALL verify stall: entry pc 0x80000004 valid, id_ready_i=0 for 3 cycles -> outputs unchanged; next accept then 0x80000008 follows.
REQ-033 SHALL verify redirect: redirect_i=1, redirect_pc_i=0x80000100 with id_ready_i=0 in cycle N -> if_valid_o=0 in N+1, if_pc_o=0x80000100 valid in N+2; fetch_cnt_o unchanged.
REQ-034 SHALL verify faults: redirect to 0x80000102 -> entry exc=1, inst 0x00000013, pc 0x80000102; after accept if_valid_o stays 0; redirect to 0x80000400 likewise faults; redirect to 0x80000000 resumes.
REQ-035 SHALL verify mid-operation reset: rst_n=0 for one cycle during stall in HALT -> all outputs at REQ-029 values, then fetch resumes at 0x80000000.
REQ-036 SHALL verify counter wrap: force fetch_cnt_o 0xFFFFFFFF, one non-fault accept -> 0x00000000.
